// File: rtl/fetch_pc_unit_if.sv
// ============================================================================
// Module      : fetch_pc_unit_if
// Description : Fetch address / instruction word link between the PC
//               sequencer (master) and instruction memory (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_pc_unit_if;
    logic [31:0] pc;
    logic [31:0] inp_instn;

    modport master (output pc, input inp_instn);
    modport slave  (input pc, output inp_instn);
endinterface

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
// ============================================================================
// Module      : fetch_pc_unit
// Description : IF-stage program-counter sequencer with IF/ID register,
//               stall hold, branch redirect and optional END_PC halt
//               (enabled by defining FETCH_HALT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] END_PC   = 32'd28
) (
    input  wire logic           clk,
    input  wire logic           reset,
    input  wire logic           stall_flag,
    input  wire logic           branch_taken,
    input  wire logic [31:0]    branch_target,
    fetch_pc_unit_if.master     mem,
    output logic [31:0]         if_id_instn,
    output logic [31:0]         if_id_pc,
    output logic                if_id_valid,
    output logic [15:0]         fetch_count,
    output logic                misalign_err,
    output logic                halt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
`ifdef FETCH_HALT_EN
        , S_HALT = 2'd3
`endif
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_instn;
    logic [31:0] w_instn_nxt;
    logic [31:0] r_ifpc;
    logic [31:0] w_ifpc_nxt;
    logic        r_valid;
    logic        w_valid_nxt;
    logic [15:0] r_count;
    logic [15:0] w_count_nxt;
    logic        r_misalign;
    logic        w_misalign_nxt;

`ifdef FETCH_HALT_EN
    wire logic w_at_end = (r_pc == END_PC);
`else
    wire logic w_unused_at_end = (r_pc == END_PC);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_instn    <= 32'd0;
            r_ifpc     <= 32'd0;
            r_valid    <= 1'b0;
            r_count    <= 16'd0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instn    <= w_instn_nxt;
            r_ifpc     <= w_ifpc_nxt;
            r_valid    <= w_valid_nxt;
            r_count    <= w_count_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instn_nxt    = r_instn;
        w_ifpc_nxt     = r_ifpc;
        w_valid_nxt    = r_valid;
        w_count_nxt    = r_count;
        w_misalign_nxt = r_misalign;

        case (r_state)
            // Memory needs one cycle to settle on RESET_PC before capture.
            S_IDLE: w_state_nxt = S_RUN;

            S_RUN, S_STALL: begin
                if (branch_taken) begin
                    w_pc_nxt    = {branch_target[31:2], 2'b00};
                    w_valid_nxt = 1'b0;
                    if (branch_target[1:0] != 2'b00) begin
                        w_misalign_nxt = 1'b1;
                    end
                    w_state_nxt = S_RUN;
                end else if (stall_flag) begin
                    w_state_nxt = S_STALL;
`ifdef FETCH_HALT_EN
                end else if (w_at_end) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_HALT;
`endif
                end else begin
                    w_instn_nxt = mem.inp_instn;
                    w_ifpc_nxt  = r_pc;
                    w_valid_nxt = 1'b1;
                    w_count_nxt = r_count + 16'd1;
                    w_pc_nxt    = r_pc + 32'd4;
                    w_state_nxt = S_RUN;
                end
            end

`ifdef FETCH_HALT_EN
            S_HALT: w_valid_nxt = 1'b0;
`endif

            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign mem.pc       = r_pc;
    assign if_id_instn  = r_instn;
    assign if_id_pc     = r_ifpc;
    assign if_id_valid  = r_valid;
    assign fetch_count  = r_count;
    assign misalign_err = r_misalign;

`ifdef FETCH_HALT_EN
    assign halt = (r_state == S_HALT);
`else
    assign halt = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Program-counter sequencer for the IF stage: drives `pc` into the instruction memory, captures the instruction returned on the same cycle into the IF/ID pipeline register, and handles stalls, branch redirects and end-of-program halt. It is the initiating end of the pc → instruction interface. Downstream decode reads `if_id_*`; the hazard unit drives `stall_flag`; the branch resolver drives `branch_taken`/`branch_target`.

## Interface
Parameters:
- `RESET_PC`, 32'd0, first fetch address after reset
- `END_PC`, 32'd28, halt address (used only with `FETCH_HALT_EN`)

Ports:
- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `stall_flag`  in  1  1 = hold pc and IF/ID register
- `branch_taken`  in  1  1 = redirect fetch to `branch_target` this cycle
- `branch_target`  in  32  redirect byte address
- `inp_instn`  in  32  instruction word from memory for current `pc` (combinational, same cycle)
- `pc`  out  32  fetch address to instruction memory
- `if_id_instn`  out  32  registered instruction
- `if_id_pc`  out  32  address of `if_id_instn`
- `if_id_valid`  out  1  IF/ID register holds a real instruction
- `fetch_count`  out  16  number of instructions accepted into IF/ID, wraps at 2^16
- `misalign_err`  out  1  sticky; a branch target had bits [1:0] ≠ 0
- `halt`  out  1  fetch has stopped at `END_PC`

## Operation
- States: IDLE, RUN, STALL, HALT.
- Reset (reset=0, any time, async): state IDLE; `pc`=RESET_PC; `if_id_instn`=0; `if_id_pc`=0; `if_id_valid`=0; `fetch_count`=0; `misalign_err`=0; `halt`=0.
- IDLE: first edge after reset release → RUN, no capture (memory settles on RESET_PC).
- RUN/STALL, per edge, priority order:
  1. `branch_taken`=1: `pc` ← {branch_target[31:2],2'b00}; `if_id_valid` ← 0 (flush); `misalign_err` ← 1 if branch_target[1:0]≠0; → RUN. Branch beats stall.
  2. `stall_flag`=1: `pc`, `if_id_*`, `fetch_count` held; → STALL.
  3. Otherwise: `if_id_instn` ← inp_instn; `if_id_pc` ← pc; `if_id_valid` ← 1; `fetch_count` ← +1; `pc` ← pc+4 (mod 2^32, 32'hFFFFFFFC wraps to 0); → RUN.
- HALT (only with `FETCH_HALT_EN`): `pc` held, `if_id_valid` ← 0, `halt`=1; inputs ignored; exits only via reset.

## Timing
- Fetch latency: instruction at `pc` appears on `if_id_instn` one edge after `pc` is presented with no stall/branch.
- Steady state: one instruction per cycle.
- Redirect: one bubble (`if_id_valid`=0 for one cycle); target instruction valid on the second edge after the branch edge.
- Stall: zero-latency hold; release resumes capture on the same edge `stall_flag` is seen 0.
- `halt` asserts on the edge where `pc`==END_PC would otherwise be captured; the END_PC instruction is not captured.

## Configuration
- `FETCH_HALT_EN` defined: HALT state present; compare `pc`==END_PC in RUN with no stall/branch → HALT.
- Not defined: HALT state removed, `halt` tied 0, fetch runs indefinitely with pc wrap.

## Test plan
- Reset release, no stall, memory word = address: after 3 edges in RUN, `if_id_pc`=8, `if_id_instn`=8, `pc`=12, `fetch_count`=3.
- `stall_flag`=1 for 4 cycles at pc=8: `pc`=8, `if_id_pc`=4, `fetch_count` unchanged; release → next edge `if_id_pc`=8.
- `branch_taken`=1 with target 0x40 while `stall_flag`=1: next edge `pc`=0x40, `if_id_valid`=0; following edge `if_id_pc`=0x40, valid=1.
- Branch target 0x43: `pc`=0x40, `misalign_err`=1 and stays 1 until reset.
- `FETCH_HALT_EN`, END_PC=28: after 7 captures (`if_id_pc`=24), `halt`=1, `pc`=28, `if_id_valid`=0; without macro, `if_id_pc`=28 captured next.
- Assert reset mid-stall at pc=0x20: all outputs return to reset values immediately, without a clock edge.
